// File: rtl/pa_scan_display.sv
// Arithmetic-progression generator with a time-multiplexed N-digit 7-segment scanner.
// Optional build macro PA_BCD_EN selects packed-BCD arithmetic and display.
module pa_scan_display #(
  parameter int CLK_HZ   = 125000000,
  parameter int STEP_HZ  = 1,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 64
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   first,
  input  logic [3:0]            step,
  output logic [4*DIGITS-1:0]   term,
  output logic                  tick,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dsel
);

  localparam int W  = 4 * DIGITS;
  localparam int TC = CLK_HZ / STEP_HZ - 1;
  localparam int PW = (TC < 2) ? 1 : $clog2(TC + 1);
  localparam int SW = (SCAN_DIV < 3) ? 1 : $clog2(SCAN_DIV);
  localparam int IW = (DIGITS < 3) ? 1 : $clog2(DIGITS);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic [W-1:0]      term_q, term_d;
  logic              wrap_q, wrap_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [W-1:0]      snap_q, snap_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dsel_q, dsel_d;

  logic              tick_now;
  logic              scan_end;
  logic [W:0]        sum;
  logic [3:0]        nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  // Returns {carry, sum}; carry is the overflow out of the displayed range.
  function automatic logic [W:0] add_step(input logic [W-1:0] a, input logic [3:0] b);
    logic [W:0] r;
`ifdef PA_BCD_EN
    logic [4:0] s;
    logic       c;
    logic [3:0] bb;
    r  = '0;
    c  = 1'b0;
    bb = (b > 4'd9) ? 4'd9 : b;
    for (int i = 0; i < DIGITS; i++) begin
      s = {1'b0, a[4*i +: 4]} + {4'b0000, c} + ((i == 0) ? {1'b0, bb} : 5'd0);
      c = (s > 5'd9);
      if (c) s = s + 5'd6;
      r[4*i +: 4] = s[3:0];
    end
    r[W] = c;
`else
    r = {1'b0, a} + {{(W-3){1'b0}}, b};
`endif
    return r;
  endfunction

  function automatic logic [W-1:0] load_val(input logic [W-1:0] f);
    logic [W-1:0] r;
`ifdef PA_BCD_EN
    r = '0;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = (f[4*i +: 4] > 4'd9) ? 4'd9 : f[4*i +: 4];
`else
    r = f;
`endif
    return r;
  endfunction

  always_comb begin
    tick_now = (presc_q == PW'(TC));
    sum      = add_step(term_q, step);

    presc_d = presc_q;
    term_d  = term_q;
    wrap_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      term_d  = load_val(first);
    end else begin
      presc_d = tick_now ? '0 : presc_q + PW'(1);
      if (tick_now && en) begin
        term_d = sum[W-1:0];
        wrap_d = sum[W];
      end
    end
    tick_d = (presc_d == PW'(TC));

    scan_end = (scan_q == SW'(SCAN_DIV - 1));
    scan_d   = scan_end ? '0 : scan_q + SW'(1);
    idx_d    = idx_q;
    snap_d   = snap_q;
    if (scan_end) begin
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      // A new frame latches the term so every digit of the frame agrees.
      if (idx_d == '0) snap_d = term_q;
    end

    nib = 4'h0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_q == IW'(i)) nib = snap_q[4*i +: 4];
    // Blank during the last cycle of a slot so the next digit never ghosts.
    seg_d  = scan_end ? 7'h7F : ~hex7(nib);
    dsel_d = DIGITS'(1) << idx_q;
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
      term_q  <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      seg_q   <= 7'h7F;
      dsel_q  <= '0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
      term_q  <= term_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      dsel_q  <= dsel_d;
    end
  end

  assign term = term_q;
  assign tick = tick_q;
  assign wrap = wrap_q;
  assign seg  = seg_q;
  assign dsel = dsel_q;

endmodule

// File: tb/tb_pa_scan_display.sv
// Bench for pa_scan_display: vector table, hand sequences and a randomized run
// checked every cycle against an arithmetic reference model (honours PA_BCD_EN).
module tb_pa_scan_display;

  localparam int CLK_HZ   = 8;
  localparam int STEP_HZ  = 1;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 4;
  localparam int W        = 4 * DIGITS;
  localparam int TC       = CLK_HZ / STEP_HZ - 1;

  logic              sysclk = 1'b0;
  logic              rst    = 1'b0;
  logic              en     = 1'b0;
  logic              load   = 1'b0;
  logic [W-1:0]      first  = '0;
  logic [3:0]        step   = '0;
  logic [W-1:0]      term;
  logic              tick;
  logic              wrap;
  logic [6:0]        seg;
  logic [DIGITS-1:0] dsel;

  pa_scan_display #(
    .CLK_HZ(CLK_HZ), .STEP_HZ(STEP_HZ), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
  ) dut (
    .sysclk(sysclk), .rst(rst), .en(en), .load(load), .first(first), .step(step),
    .term(term), .tick(tick), .wrap(wrap), .seg(seg), .dsel(dsel)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  logic [6:0] hexpat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state, as seen after the most recent clock edge.
  int                m_term, m_presc, m_cyc, m_snap;
  bit                m_wrap, m_tick;
  logic [6:0]        m_seg;
  logic [DIGITS-1:0] m_dsel;

  typedef struct {
    logic [W-1:0] first;
    logic [3:0]   step;
    int           nticks;
    logic [W-1:0] exp_term;
    bit           exp_wrap;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int to_val(input int t);
    int v;
`ifdef PA_BCD_EN
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + ((t >> (4 * i)) & 15);
`else
    v = t;
`endif
    return v;
  endfunction

  function automatic int from_val(input int v);
    int t;
`ifdef PA_BCD_EN
    t = 0;
    for (int i = 0; i < DIGITS; i++) begin
      t = t | ((v % 10) << (4 * i));
      v = v / 10;
    end
`else
    t = v;
`endif
    return t;
  endfunction

  function automatic int base_mod();
`ifdef PA_BCD_EN
    int b = 1;
    for (int i = 0; i < DIGITS; i++) b = b * 10;
    return b;
`else
    return 1 << W;
`endif
  endfunction

  function automatic int clamp_first(input int f);
    int r;
`ifdef PA_BCD_EN
    r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      int d;
      d = (f >> (4 * i)) & 15;
      if (d > 9) d = 9;
      r = r | (d << (4 * i));
    end
`else
    r = f;
`endif
    return r;
  endfunction

  function automatic int clamp_step(input int s);
`ifdef PA_BCD_EN
    return (s > 9) ? 9 : s;
`else
    return s;
`endif
  endfunction

  task automatic model_reset();
    m_term = 0; m_presc = 0; m_cyc = 0; m_snap = 0;
    m_wrap = 0; m_tick = 0; m_seg = 7'h7F; m_dsel = '0;
  endtask

  task automatic model_edge();
    int  idx, v;
    bit  tk;
    tk  = (m_presc == TC);
    idx = (m_cyc / SCAN_DIV) % DIGITS;
    m_dsel = '0;
    m_dsel[idx] = 1'b1;
    m_seg = (m_cyc % SCAN_DIV == SCAN_DIV - 1) ? 7'h7F : ~hexpat[(m_snap >> (4 * idx)) & 15];
    if ((m_cyc + 1) % (SCAN_DIV * DIGITS) == 0) m_snap = m_term;
    m_cyc++;
    m_wrap = 0;
    if (load) begin
      m_term  = clamp_first(int'(first));
      m_presc = 0;
    end else begin
      m_presc = tk ? 0 : m_presc + 1;
      if (tk && en) begin
        v      = to_val(m_term) + clamp_step(int'(step));
        m_wrap = (v >= base_mod());
        m_term = from_val(v % base_mod());
      end
    end
    m_tick = (m_presc == TC);
  endtask

  task automatic check_all();
    chk("term", term, m_term);
    chk("wrap", wrap, m_wrap);
    chk("tick", tick, m_tick);
    chk("seg", seg, m_seg);
    chk("dsel", dsel, m_dsel);
  endtask

  task automatic cycle();
    @(posedge sysclk);
    model_edge();
    @(negedge sysclk);
    check_all();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (tick !== 1'b1 && n < 20) begin
      cycle();
      n++;
    end
    if (n >= 20) chk("tick_timeout", tick, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_seg"}, seg, 7'h7F);
    chk({tag, "_dsel"}, dsel, 0);
    chk({tag, "_term"}, term, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_wrap"}, wrap, 0);
  endtask

`ifdef PA_BCD_EN
  localparam logic [6:0] SCAN_D0 = 7'h10;  // digit 9 (3A clamps to 39)
`else
  localparam logic [6:0] SCAN_D0 = 7'h08;  // digit A
`endif
  localparam logic [6:0] SCAN_D1 = 7'h30;  // digit 3
  localparam logic [6:0] NEW_D1  = 7'h12;  // digit 5

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[$];
    int   n, nblank, waited;
    bit   seen01;
    logic [DIGITS-1:0] prev_dsel;

`ifdef PA_BCD_EN
    vt.push_back('{8'h98, 4'd5, 1, 8'h03, 1'b1});
    vt.push_back('{8'h27, 4'd5, 1, 8'h32, 1'b0});
    vt.push_back('{8'h99, 4'd1, 1, 8'h00, 1'b1});
    vt.push_back('{8'h5C, 4'd0, 1, 8'h59, 1'b0});
    vt.push_back('{8'h10, 4'd15, 1, 8'h19, 1'b0});
    vt.push_back('{8'hA3, 4'd7, 1, 8'h00, 1'b1});
    vt.push_back('{8'h05, 4'd3, 3, 8'h14, 1'b0});
`else
    vt.push_back('{8'h05, 4'd3, 0, 8'h05, 1'b0});
    vt.push_back('{8'h05, 4'd3, 1, 8'h08, 1'b0});
    vt.push_back('{8'h05, 4'd3, 2, 8'h0B, 1'b0});
    vt.push_back('{8'h05, 4'd3, 3, 8'h0E, 1'b0});
    vt.push_back('{8'hFE, 4'd3, 1, 8'h01, 1'b1});
    vt.push_back('{8'hFF, 4'd1, 1, 8'h00, 1'b1});
    vt.push_back('{8'hF0, 4'd15, 1, 8'hFF, 1'b0});
    vt.push_back('{8'h80, 4'd0, 2, 8'h80, 1'b0});
    vt.push_back('{8'h7D, 4'd9, 1, 8'h86, 1'b0});
`endif

    // Reset held, then release away from the active edge.
    repeat (3) @(negedge sysclk);
    check_reset_vals("rst_hold");
    model_reset();
    rst = 1'b1;
    cycle();
    chk("first_dsel", dsel, 1);

    // Vector table: load, run n ticks, compare term/wrap.
    foreach (vt[k]) begin
      load = 1'b1; first = vt[k].first; step = vt[k].step; en = 1'b1;
      cycle();
      load = 1'b0;
      chk("load_term", term, clamp_first(int'(vt[k].first)));
      for (int t = 0; t < vt[k].nticks; t++) begin
        wait_tick(n);
        if (t == 0) chk("tick_gap_after_load", n, TC);
        cycle();
      end
      chk("vec_term", term, vt[k].exp_term);
      chk("vec_wrap", wrap, vt[k].exp_wrap);
      if (vt[k].exp_wrap) begin
        cycle();
        chk("wrap_one_cycle", wrap, 0);
      end
    end

    // Load colliding with tick: load wins, prescaler restarts.
    step = 4'd1; en = 1'b1;
    wait_tick(n);
    load = 1'b1; first = 8'h42;
    cycle();
    load = 1'b0;
    chk("collide_term", term, 8'h42);
    wait_tick(n);
    chk("collide_gap", n + 1, TC + 1);

    // Scan pattern with a held term.
    en = 1'b0; load = 1'b1; first = 8'h3A;
    cycle();
    load = 1'b0;
    repeat (3 * SCAN_DIV * DIGITS) cycle();
    nblank = 0;
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      cycle();
      if (seg == 7'h7F) nblank++;
      else if (dsel == 2'b01) chk("scan_d0", seg, SCAN_D0);
      else chk("scan_d1", seg, SCAN_D1);
    end
    chk("blank_count", nblank, 4);

    // Snapshot: load early in a digit-1 slot; digit 1 keeps the old value this frame.
    waited = 0;
    prev_dsel = dsel;
    cycle();
    while (!(dsel == 2'b10 && prev_dsel == 2'b01) && waited < 20) begin
      prev_dsel = dsel;
      cycle();
      waited++;
    end
    if (waited >= 20) chk("snap_slot_timeout", dsel, 2'b10);
    load = 1'b1; first = 8'h51;
    cycle();
    load = 1'b0;
    seen01 = 1'b0;
    for (int c = 0; c < 3 * SCAN_DIV * DIGITS; c++) begin
      cycle();
      if (seg != 7'h7F) begin
        if (dsel == 2'b01) seen01 = 1'b1;
        else chk("snap_digit1", seg, seen01 ? NEW_D1 : SCAN_D1);
      end
    end

    // Randomized run with a mid-operation asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      load  = ($urandom_range(15) == 0);
      first = W'($urandom);
      step  = 4'($urandom);
      en    = ($urandom_range(3) != 0);
      if (i == 200) begin
        load = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals("rst_mid");
        model_reset();
        @(negedge sysclk);
        check_reset_vals("rst_mid_hold");
        rst = 1'b1;
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
